rs_issue_select: RTL and testbench
==================================

Name: rs_issue_select

Overview:
- Issue stage directly downstream of the reservation station lines.
- Each cycle it scans all RS lines, selects up to ISSUE_WIDTH ready lines and returns a one-hot-per-line grant to the RS so those lines are freed.
- Selection is round-robin and respects structural limits: one multiplier (non-pipelined, multi-cycle) and one memory port.
- Granted lines are latched into the RS/IS pipeline register that feeds execute.

Parameters:
- RS_SIZE, 8, number of RS lines scanned.
- ISSUE_WIDTH, 3, issue slots per cycle; matches the CDB width.
- MULT_LAT, 4, multiplier occupancy in cycles (1 = pipelined behaviour).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- squash  in  1  branch-mispredict flush.
- ex_stall  in  1  execute cannot accept new packets this cycle.
- rs_lines  in  RS_LINE[RS_SIZE]  current contents of every RS line.
- rs_not_ready  in  [RS_SIZE]  per-line not_ready from RS_ONE_LINE.
- rs_grant  out  [RS_SIZE]  combinational; line i issues this cycle, RS clears it at the next edge.
- issue_packet  out  IS_PACKET[ISSUE_WIDTH]  registered packets to execute.
- issue_valid  out  [ISSUE_WIDTH]  registered slot valid.

Behaviour:
- Line i is eligible when rs_lines[i].busy && !rs_not_ready[i] && its class limit allows it.
- Class decode:
  - MEM: rd_mem|wr_mem.
  - MULT: alu_func in {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}.
  - ALU: everything else.
- Scan starts at rr_ptr and proceeds in increasing index mod RS_SIZE. The first ISSUE_WIDTH eligible lines are granted and mapped to slots 0.. in scan order.
- Per-cycle limits: at most 1 MEM. At most 1 MULT, and only when mult_cnt==0. A line rejected by a limit is skipped and the scan continues.
- Latency: a line ready in cycle N is granted combinationally in N; its issue_packet/issue_valid appear after the edge ending N. No same-cycle CDB wakeup (not_ready is registered in the RS).
- issue_packet fields come from the granted RS_LINE: inst, PC, NPC, V1→rs1_value, V2→rs2_value, T→dest tag, opa/opb select, alu_func, rd_mem, wr_mem, cond, uncond, halt, illegal, csr_op, valid. Unused slots: issue_valid=0, packet=NOP defaults.
- rr_ptr:
  - After a cycle with ≥1 grant: (index of last granted line + 1) mod RS_SIZE.
  - Otherwise unchanged.
- mult_cnt:
  - Loads MULT_LAT-1 at the edge ending a MULT-grant cycle.
  - Otherwise decrements when nonzero, independent of ex_stall.
  - Result: consecutive MULT grants are exactly MULT_LAT cycles apart.
- ex_stall=1: rs_grant=0; issue registers, rr_ptr and the next-grant state hold; mult_cnt still decrements.
- squash=1 (priority over ex_stall): rs_grant=0; next edge clears issue_valid to 0 and mult_cnt to 0; rr_ptr holds.
- reset=1: next edge sets issue_valid=0, packets=NOP, rr_ptr=0, mult_cnt=0; rs_grant=0 while reset is asserted. Reset mid-multiply abandons it.
- All-empty RS or all not_ready: no grants, issue_valid=0 next cycle.

Decomposition:
- Add to sys_defs.svh:
  - FU_CLASS enum {FU_ALU, FU_MULT, FU_MEM}.
  - IS_PACKET typedef.
  - `RS_SIZE, `ISSUE_WIDTH, `MULT_LAT macros.
- One sub-module, rs_rr_picker: rotating priority scan that takes an eligibility vector, rr_ptr and limits, and returns rs_grant plus slot→line indices (combinational).
- The parent holds the registers, class decode and mult_cnt.

Test Plan:
- Reset asserted 2 cycles, then deasserted with the RS empty → rs_grant=0, issue_valid=3'b000, rr_ptr=0.
- ALU lines 1,3,5,6 ready, rr_ptr=0 → rs_grant=8'b0010_1010. Next cycle slots 0/1/2 = lines 1/3/5, rr_ptr=6. Line 6 then granted to slot 0.
- MUL lines 0 and 2 ready at cycle N, MULT_LAT=4 → line 0 granted at N, line 2 granted at N+4 and not earlier. ALU line 4 still granted at N alongside line 0.
- Loads on lines 2,4 plus ALU on line 5 → cycle 1 grants lines 2 and 5; cycle 2 grants line 4.
- ex_stall=1 for 2 cycles with 3 lines ready → rs_grant=0, issue_packet/issue_valid unchanged. Issue resumes the cycle after ex_stall falls.
- squash during mult_cnt=2 with issue_valid=3'b111 → next cycle issue_valid=0, mult_cnt=0. A ready MUL is granted the following cycle.

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// rtl/rs_issue_select_pkg.sv - shared types, sizes and helpers for the issue-select stage
//
// Contents:
//   DEF_RS_SIZE / DEF_ISSUE_WIDTH / DEF_MULT_LAT : default structural sizes
//   fu_class_t   : functional-unit class of an RS line
//   alu_func_t   : ALU operation encoding
//   rs_line_t    : one reservation-station line as seen by issue
//   is_packet_t  : one issue slot handed to execute
//   fu_class_of(), to_packet(), nop_packet() : decode / conversion helpers
package rs_issue_select_pkg;

    localparam int DEF_RS_SIZE     = 8;
    localparam int DEF_ISSUE_WIDTH = 3;
    localparam int DEF_MULT_LAT    = 4;
    localparam int TAG_W           = 6;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2
    } fu_class_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13
    } alu_func_t;

    typedef struct packed {
        logic              busy;
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [31:0]       npc;
        logic [31:0]       v1;
        logic [31:0]       v2;
        logic [TAG_W-1:0]  t;
        logic [1:0]        opa_select;
        logic [3:0]        opb_select;
        alu_func_t         alu_func;
        logic              rd_mem;
        logic              wr_mem;
        logic              cond_branch;
        logic              uncond_branch;
        logic              halt;
        logic              illegal;
        logic              csr_op;
        logic              valid;
    } rs_line_t;

    typedef struct packed {
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [31:0]       npc;
        logic [31:0]       rs1_value;
        logic [31:0]       rs2_value;
        logic [TAG_W-1:0]  dest_tag;
        logic [1:0]        opa_select;
        logic [3:0]        opb_select;
        alu_func_t         alu_func;
        logic              rd_mem;
        logic              wr_mem;
        logic              cond_branch;
        logic              uncond_branch;
        logic              halt;
        logic              illegal;
        logic              csr_op;
        logic              valid;
    } is_packet_t;

    // Memory ops win over the ALU function field: a load/store still
    // carries ALU_ADD for its address computation.
    function automatic fu_class_t fu_class_of(input rs_line_t l);
        if (l.rd_mem || l.wr_mem) begin
            return FU_MEM;
        end
        if (l.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) begin
            return FU_MULT;
        end
        return FU_ALU;
    endfunction

    function automatic is_packet_t nop_packet();
        is_packet_t p;
        p          = '0;
        p.inst     = NOP_INST;
        p.alu_func = ALU_ADD;
        return p;
    endfunction

    function automatic is_packet_t to_packet(input rs_line_t l);
        is_packet_t p;
        p.inst          = l.inst;
        p.pc            = l.pc;
        p.npc           = l.npc;
        p.rs1_value     = l.v1;
        p.rs2_value     = l.v2;
        p.dest_tag      = l.t;
        p.opa_select    = l.opa_select;
        p.opb_select    = l.opb_select;
        p.alu_func      = l.alu_func;
        p.rd_mem        = l.rd_mem;
        p.wr_mem        = l.wr_mem;
        p.cond_branch   = l.cond_branch;
        p.uncond_branch = l.uncond_branch;
        p.halt          = l.halt;
        p.illegal       = l.illegal;
        p.csr_op        = l.csr_op;
        p.valid         = l.valid;
        return p;
    endfunction

endpackage

// File: rtl/rs_issue_select_rr_picker.sv
// rtl/rs_issue_select_rr_picker.sv - rotating-priority selector with per-class limits
//
// Ports:
//   ready        in   per-line candidate (busy, operands ready, issue enabled)
//   is_mult      in   per-line multiplier class
//   is_mem       in   per-line memory class
//   mult_free    in   multiplier can accept a new op this cycle
//   rr_ptr       in   line index where the scan starts
//   grant        out  one bit per granted line
//   slot_valid   out  slot s carries a granted line
//   slot_idx     out  line index held by slot s (scan order)
//   last_idx     out  last line granted in scan order
//   any_grant    out  at least one grant this cycle
//   mult_granted out  the multiplier was claimed this cycle
module rs_rr_picker
#(
    parameter int RS_SIZE     = 8,
    parameter int ISSUE_WIDTH = 3,
    parameter int IDX_W       = 3
)
(
    input  logic [RS_SIZE-1:0]                   ready,
    input  logic [RS_SIZE-1:0]                   is_mult,
    input  logic [RS_SIZE-1:0]                   is_mem,
    input  logic                                 mult_free,
    input  logic [IDX_W-1:0]                     rr_ptr,
    output logic [RS_SIZE-1:0]                   grant,
    output logic [ISSUE_WIDTH-1:0]               slot_valid,
    output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]    slot_idx,
    output logic [IDX_W-1:0]                     last_idx,
    output logic                                 any_grant,
    output logic                                 mult_granted
);

    always_comb begin
        int               idx;
        int               taken;
        logic [IDX_W-1:0] line;
        logic             mem_used;
        logic             mult_used;

        grant        = '0;
        slot_valid   = '0;
        slot_idx     = '0;
        last_idx     = '0;
        any_grant    = 1'b0;
        mult_granted = 1'b0;
        idx          = 0;
        taken        = 0;
        line         = '0;
        mem_used     = 1'b0;
        mult_used    = 1'b0;

        // A line blocked by a class limit does not stop the scan; later
        // lines of other classes can still fill the remaining slots.
        for (int k = 0; k < RS_SIZE; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= RS_SIZE) begin
                idx = idx - RS_SIZE;
            end
            line = IDX_W'(idx);
            if ((taken < ISSUE_WIDTH) && ready[line] &&
                !(is_mem[line] && mem_used) &&
                !(is_mult[line] && (mult_used || !mult_free))) begin
                grant[line] = 1'b1;
                for (int s = 0; s < ISSUE_WIDTH; s++) begin
                    if (s == taken) begin
                        slot_valid[s] = 1'b1;
                        slot_idx[s]   = line;
                    end
                end
                last_idx = line;
                if (is_mem[line]) begin
                    mem_used = 1'b1;
                end
                if (is_mult[line]) begin
                    mult_used = 1'b1;
                end
                taken = taken + 1;
            end
        end

        any_grant    = |grant;
        mult_granted = mult_used;
    end

endmodule

// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - issue stage: picks ready RS lines and registers packets for execute
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   squash       in   branch-mispredict flush
//   ex_stall     in   execute cannot take new packets this cycle
//   rs_lines     in   contents of every RS line
//   rs_not_ready in   per-line operands-not-ready
//   rs_grant     out  combinational; RS frees granted lines at the next edge
//   issue_packet out  registered packets for execute
//   issue_valid  out  registered per-slot valid
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int RS_SIZE     = DEF_RS_SIZE,
    parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
    parameter int MULT_LAT    = DEF_MULT_LAT
)
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic                                ex_stall,
    input  rs_line_t   [RS_SIZE-1:0]            rs_lines,
    input  logic       [RS_SIZE-1:0]            rs_not_ready,
    output logic       [RS_SIZE-1:0]            rs_grant,
    output is_packet_t [ISSUE_WIDTH-1:0]        issue_packet,
    output logic       [ISSUE_WIDTH-1:0]        issue_valid
);

    localparam int IDX_W = (RS_SIZE  > 1) ? $clog2(RS_SIZE)  : 1;
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    logic [IDX_W-1:0]                  rr_ptr;
    logic [CNT_W-1:0]                  mult_cnt;

    logic                              issue_en;
    logic [RS_SIZE-1:0]                eligible;
    logic [RS_SIZE-1:0]                is_mult;
    logic [RS_SIZE-1:0]                is_mem;
    logic [ISSUE_WIDTH-1:0]            slot_valid;
    logic [ISSUE_WIDTH-1:0][IDX_W-1:0] slot_idx;
    logic [IDX_W-1:0]                  last_idx;
    logic                              any_grant;
    logic                              mult_granted;
    is_packet_t [ISSUE_WIDTH-1:0]      next_packet;

    // Any of reset/squash/stall suppresses all grants so the RS keeps its lines.
    assign issue_en = !reset && !squash && !ex_stall;

    always_comb begin
        is_mult  = '0;
        is_mem   = '0;
        eligible = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            is_mult[i]  = (fu_class_of(rs_lines[i]) == FU_MULT);
            is_mem[i]   = (fu_class_of(rs_lines[i]) == FU_MEM);
            eligible[i] = issue_en && rs_lines[i].busy && !rs_not_ready[i];
        end
    end

    rs_rr_picker #(
        .RS_SIZE     (RS_SIZE),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .IDX_W       (IDX_W)
    ) u_picker (
        .ready        (eligible),
        .is_mult      (is_mult),
        .is_mem       (is_mem),
        .mult_free    (mult_cnt == '0),
        .rr_ptr       (rr_ptr),
        .grant        (rs_grant),
        .slot_valid   (slot_valid),
        .slot_idx     (slot_idx),
        .last_idx     (last_idx),
        .any_grant    (any_grant),
        .mult_granted (mult_granted)
    );

    always_comb begin
        next_packet = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            next_packet[s] = slot_valid[s] ? to_packet(rs_lines[slot_idx[s]]) : nop_packet();
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= '0;
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                issue_packet[s] <= nop_packet();
            end
            rr_ptr   <= '0;
            mult_cnt <= '0;
        end else if (squash) begin
            // Squash abandons any multiply in flight; rr_ptr is kept so
            // fairness continues where it left off.
            issue_valid <= '0;
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                issue_packet[s] <= nop_packet();
            end
            mult_cnt <= '0;
        end else begin
            // The multiplier keeps counting through ex_stall; mult_granted is
            // already zero while stalled because no grants are made.
            if (mult_granted) begin
                mult_cnt <= CNT_W'(MULT_LAT - 1);
            end else if (mult_cnt != '0) begin
                mult_cnt <= mult_cnt - 1'b1;
            end
            if (!ex_stall) begin
                issue_valid  <= slot_valid;
                issue_packet <= next_packet;
                if (any_grant) begin
                    rr_ptr <= (int'(last_idx) == RS_SIZE - 1) ? '0 : last_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - scoreboard bench for rs_issue_select with directed vectors
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    localparam int N = 8;
    localparam int W = 3;
    localparam int K_ALU = 0;
    localparam int K_MUL = 1;
    localparam int K_LD  = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    logic                    ex_stall;
    rs_line_t   [N-1:0]      rs_lines;
    logic       [N-1:0]      rs_not_ready;
    logic       [N-1:0]      rs_grant;
    is_packet_t [W-1:0]      issue_packet;
    logic       [W-1:0]      issue_valid;

    always #5 clock = ~clock;

    rs_issue_select #(
        .RS_SIZE     (N),
        .ISSUE_WIDTH (W),
        .MULT_LAT    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .ex_stall     (ex_stall),
        .rs_lines     (rs_lines),
        .rs_not_ready (rs_not_ready),
        .rs_grant     (rs_grant),
        .issue_packet (issue_packet),
        .issue_valid  (issue_valid)
    );

    typedef struct {
        logic [N-1:0]       grant;
        logic [W-1:0]       valid;
        is_packet_t [W-1:0] pkts;
        int                 rr;
        int                 mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   line_kind [N];

    function automatic rs_line_t make_line(input int i, input int kind);
        rs_line_t l;
        l            = '0;
        l.busy       = 1'b1;
        l.inst       = 32'hA000_0000 + 32'(i);
        l.pc         = 32'h0000_0100 + 32'(4 * i);
        l.npc        = 32'h0000_0104 + 32'(4 * i);
        l.v1         = 32'h1111_0000 + 32'(i);
        l.v2         = 32'h2222_0000 + 32'(i);
        l.t          = TAG_W'(i + 8);
        l.opa_select = 2'd1;
        l.opb_select = 4'd2;
        l.alu_func   = (kind == K_MUL) ? ALU_MUL : ((kind == K_LD) ? ALU_ADD : ALU_XOR);
        l.rd_mem     = (kind == K_LD);
        l.valid      = 1'b1;
        return l;
    endfunction

    function automatic is_packet_t exp_packet(input int i);
        rs_line_t   l;
        is_packet_t p;
        l               = make_line(i, line_kind[i]);
        p               = '0;
        p.inst          = l.inst;
        p.pc            = l.pc;
        p.npc           = l.npc;
        p.rs1_value     = l.v1;
        p.rs2_value     = l.v2;
        p.dest_tag      = l.t;
        p.opa_select    = l.opa_select;
        p.opb_select    = l.opb_select;
        p.alu_func      = l.alu_func;
        p.rd_mem        = l.rd_mem;
        p.valid         = 1'b1;
        return p;
    endfunction

    task automatic set_line(input int i, input int kind);
        line_kind[i] = kind;
        rs_lines[i]  = make_line(i, kind);
    endtask

    task automatic clr(input int i);
        rs_lines[i] = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs for the current cycle: grant, slot lines (-1 = empty),
    // rr_ptr and mult_cnt.
    task automatic push(input logic [N-1:0] g, input int s0, input int s1, input int s2,
                        input int rr, input int mc);
        exp_t e;
        int   sl [W];
        sl[0]   = s0;
        sl[1]   = s1;
        sl[2]   = s2;
        e.grant = g;
        e.rr    = rr;
        e.mc    = mc;
        e.valid = '0;
        for (int s = 0; s < W; s++) begin
            if (sl[s] >= 0) begin
                e.valid[s] = 1'b1;
                e.pkts[s]  = exp_packet(sl[s]);
            end else begin
                e.pkts[s]  = nop_packet();
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("rs_grant", 256'(rs_grant), 256'(e.grant));
                check_val("issue_valid", 256'(issue_valid), 256'(e.valid));
                for (int s = 0; s < W; s++) begin
                    check_val($sformatf("slot%0d_packet", s), 256'(issue_packet[s]), 256'(e.pkts[s]));
                end
                if (e.rr >= 0) begin
                    check_val("rr_ptr", 256'(dut.rr_ptr), 256'(e.rr));
                end
                if (e.mc >= 0) begin
                    check_val("mult_cnt", 256'(dut.mult_cnt), 256'(e.mc));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        squash       = 1'b0;
        ex_stall     = 1'b0;
        rs_lines     = '0;
        rs_not_ready = '0;
        for (int i = 0; i < N; i++) line_kind[i] = K_ALU;

        // reset for two edges; a ready line during reset must not be granted
        tick(); push(8'b0000_0000, -1, -1, -1, 0, 0);
        set_line(0, K_ALU);
        tick(); push(8'b0000_0000, -1, -1, -1, 0, 0);
        reset = 1'b0; clr(0);
        tick(); push(8'b0000_0000, -1, -1, -1, 0, 0);

        // ALU lines 1,3,5,6 from rr_ptr 0
        tick(); set_line(1, K_ALU); set_line(3, K_ALU); set_line(5, K_ALU); set_line(6, K_ALU);
        push(8'b0010_1010, -1, -1, -1, 0, 0);
        tick(); clr(1); clr(3); clr(5);
        push(8'b0100_0000, 1, 3, 5, 6, 0);
        tick(); clr(6); set_line(3, K_ALU); rs_not_ready[3] = 1'b1;
        push(8'b0000_0000, 6, -1, -1, 7, 0);
        tick(); push(8'b0000_0000, -1, -1, -1, 7, 0);

        // multiplier spacing: MUL 0 and 2, ALU 4
        tick(); clr(3); rs_not_ready = '0;
        set_line(0, K_MUL); set_line(2, K_MUL); set_line(4, K_ALU);
        push(8'b0001_0001, -1, -1, -1, 7, 0);
        tick(); clr(0); clr(4);
        push(8'b0000_0000, 0, 4, -1, 5, 3);
        tick(); push(8'b0000_0000, -1, -1, -1, 5, 2);
        tick(); push(8'b0000_0000, -1, -1, -1, 5, 1);
        tick(); push(8'b0000_0100, -1, -1, -1, 5, 0);
        tick(); clr(2);
        push(8'b0000_0000, 2, -1, -1, 3, 3);

        // bring rr_ptr to 0, then the memory-port limit
        tick(); set_line(7, K_ALU);
        push(8'b1000_0000, -1, -1, -1, 3, 2);
        tick(); clr(7); set_line(2, K_LD); set_line(4, K_LD); set_line(5, K_ALU);
        push(8'b0010_0100, 7, -1, -1, 0, 1);
        tick(); clr(2); clr(5);
        push(8'b0001_0000, 2, 5, -1, 6, 0);

        // ex_stall for two cycles with three ready lines
        tick(); clr(4); set_line(0, K_ALU); set_line(1, K_ALU); set_line(3, K_ALU); ex_stall = 1'b1;
        push(8'b0000_0000, 4, -1, -1, 5, 0);
        tick(); push(8'b0000_0000, 4, -1, -1, 5, 0);
        tick(); ex_stall = 1'b0;
        push(8'b0000_1011, 4, -1, -1, 5, 0);

        // squash while mult_cnt==2 and all slots valid
        tick(); clr(0); clr(1); clr(3); set_line(4, K_MUL); set_line(5, K_ALU); set_line(6, K_ALU);
        push(8'b0111_0000, 0, 1, 3, 4, 0);
        tick(); clr(4); clr(5); clr(6);
        set_line(0, K_ALU); set_line(1, K_ALU); set_line(2, K_ALU); set_line(7, K_MUL);
        push(8'b0000_0111, 4, 5, 6, 7, 3);
        tick(); clr(0); clr(1); clr(2); squash = 1'b1;
        push(8'b0000_0000, 0, 1, 2, 3, 2);
        tick(); squash = 1'b0;
        push(8'b1000_0000, -1, -1, -1, 3, 0);
        tick(); clr(7);
        push(8'b0000_0000, 7, -1, -1, 0, 3);

        // mult_cnt keeps decrementing under ex_stall
        tick(); ex_stall = 1'b1; set_line(1, K_ALU);
        push(8'b0000_0000, -1, -1, -1, 0, 2);
        tick(); push(8'b0000_0000, -1, -1, -1, 0, 1);
        tick(); ex_stall = 1'b0;
        push(8'b0000_0010, -1, -1, -1, 0, 0);
        tick(); clr(1);
        push(8'b0000_0000, 1, -1, -1, 2, 0);
        tick(); push(8'b0000_0000, -1, -1, -1, 2, 0);

        tick();
        tick();
        check_val("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
